seq_alu: RTL and testbench

//   Parametrised successor to the single-cycle datapath ALU. Owns its carry/zero

---
 rtl/seq_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU with owned carry/zero flags, start/busy/done handshake and
// iterative unsigned MUL (shift-add) and DIVU (restoring), one bit per cycle.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] mem,
  input  logic [WIDTH-1:0] wreg,
  input  logic             flag_load,
  input  logic             flag_c_in,
  input  logic             flag_z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero_out,
  output logic             pc_skip
);

  localparam logic [3:0] OP_ROTL = 4'h0;
  localparam logic [3:0] OP_ROTR = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ZTST = 4'h7;
  localparam logic [3:0] OP_SKNZ = 4'h8;
  localparam logic [3:0] OP_SKZ  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             c_cap_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, carry_q, zero_q, skip_q;
  logic [WIDTH-1:0] result_q, result_hi_q;

  // Single-cycle datapath
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_c_we, sc_z_we, sc_skip, sc_z;

  assign add_sum = {1'b0, opa_q} + {1'b0, opb_q};
  assign sub_sum = {1'b0, opa_q} + {1'b0, ~opb_q} + (WIDTH + 1)'(1);
  assign sc_z    = (sc_res == '0);

  always_comb begin
    sc_res  = opb_q;
    sc_c    = 1'b0;
    sc_c_we = 1'b0;
    sc_z_we = 1'b0;
    sc_skip = 1'b0;
    case (op_q)
      OP_ROTL: begin
        sc_res  = {opa_q[WIDTH-2:0], c_cap_q};
        sc_c    = opa_q[WIDTH-1];
        sc_c_we = 1'b1;
      end
      OP_ROTR: begin
        sc_res  = {c_cap_q, opa_q[WIDTH-1:1]};
        sc_c    = opa_q[0];
        sc_c_we = 1'b1;
      end
      OP_ADD: begin
        sc_res  = add_sum[WIDTH-1:0];
        sc_c    = add_sum[WIDTH];
        sc_c_we = 1'b1;
        sc_z_we = 1'b1;
      end
      OP_SUB: begin
        sc_res  = sub_sum[WIDTH-1:0];
        sc_c    = sub_sum[WIDTH];
        sc_c_we = 1'b1;
        sc_z_we = 1'b1;
      end
      OP_AND: begin
        sc_res  = opa_q & opb_q;
        sc_z_we = 1'b1;
      end
      OP_OR: begin
        sc_res  = opa_q | opb_q;
        sc_z_we = 1'b1;
      end
      OP_XOR: begin
        sc_res  = opa_q ^ opb_q;
        sc_z_we = 1'b1;
      end
      OP_ZTST: begin
        sc_res  = opa_q;
        sc_z_we = 1'b1;
      end
      OP_SKNZ: begin
        sc_res  = opa_q;
        sc_skip = (opa_q != '0);
      end
      OP_SKZ: begin
        sc_res  = opa_q;
        sc_skip = (opa_q == '0);
      end
      default: sc_res = opb_q;
    endcase
  end

  // One iteration step: acc_hi holds partial product high / remainder
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok, is_mul, div_by_zero;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_c, fin_z;

  assign is_mul      = (op_q == OP_MUL);
  assign div_by_zero = (opb_q == '0);
  assign mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
  assign div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok      = (div_shift >= {1'b0, opb_q});
  assign div_diff    = div_shift[WIDTH-1:0] - opb_q;

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (is_mul) begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      acc_hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
    end
  end

  always_comb begin
    fin_res = acc_lo_q;
    fin_hi  = acc_hi_q;
    fin_c   = 1'b0;
    fin_z   = (acc_lo_q == '0);
    if (is_mul) begin
      fin_c = (acc_hi_q != '0);
    end else if (div_by_zero) begin
      fin_res = '1;
      fin_hi  = opa_q;
      fin_c   = 1'b1;
      fin_z   = 1'b0;
    end
  end

  // Control FSM and all registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      c_cap_q     <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      skip_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      skip_q <= 1'b0;
      // External load first so a completing op's flag write overrides it
      if (flag_load) begin
        carry_q <= flag_c_in;
        zero_q  <= flag_z_in;
      end
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          if (start) begin
            op_q     <= alu_op;
            opa_q    <= mem;
            opb_q    <= wreg;
            c_cap_q  <= carry_q;
            acc_hi_q <= '0;
            acc_lo_q <= (alu_op == OP_MUL) ? wreg : mem;
            cnt_q    <= '0;
            state_q  <= (alu_op == OP_MUL || alu_op == OP_DIVU) ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: begin
          result_q    <= sc_res;
          result_hi_q <= '0;
          skip_q      <= sc_skip;
          done_q      <= 1'b1;
          if (sc_c_we) carry_q <= sc_c;
          if (sc_z_we) zero_q  <= sc_z;
          state_q     <= S_IDLE;
        end
        S_ITER: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_q    <= fin_res;
            result_hi_q <= fin_hi;
            carry_q     <= fin_c;
            zero_q      <= fin_z;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;
  assign pc_skip   = skip_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu plus hand-written multi-cycle sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_op;
  logic [15:0] mem, wreg;
  logic        flag_load, flag_c_in, flag_z_in;
  logic        busy, done;
  logic [15:0] result, result_hi;
  logic        carry_out, zero_out, pc_skip;

  int tests = 0;
  int fails = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_op    (alu_op),
    .mem       (mem),
    .wreg      (wreg),
    .flag_load (flag_load),
    .flag_c_in (flag_c_in),
    .flag_z_in (flag_z_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .carry_out (carry_out),
    .zero_out  (zero_out),
    .pc_skip   (pc_skip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        skip;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    @(negedge clk);
    alu_op = v.op; mem = v.a; wreg = v.b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    check($sformatf("v%0d.done_seen", idx), 32'(seen), 32'd1);
    check($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d.result", idx), 32'(result), 32'(v.res));
    check($sformatf("v%0d.result_hi", idx), 32'(result_hi), 32'(v.hi));
    check($sformatf("v%0d.carry", idx), 32'(carry_out), 32'(v.c));
    check($sformatf("v%0d.zero", idx), 32'(zero_out), 32'(v.z));
    check($sformatf("v%0d.pc_skip", idx), 32'(pc_skip), 32'(v.skip));
    check($sformatf("v%0d.busy_at_done", idx), 32'(busy), 32'd1);
  endtask

  initial begin
    int done_cnt;
    int done_at;

    //          op    a        b        lat res      hi       c  z  skip
    vecs[0]  = '{4'h2, 16'hFFFF, 16'h0001, 1,  16'h0000, 16'h0000, 1, 1, 0};
    vecs[1]  = '{4'h3, 16'h0005, 16'h0007, 1,  16'hFFFE, 16'h0000, 0, 0, 0};
    vecs[2]  = '{4'h0, 16'hFFFE, 16'h0000, 1,  16'hFFFC, 16'h0000, 1, 0, 0};
    vecs[3]  = '{4'h1, 16'h0003, 16'h0000, 1,  16'h8001, 16'h0000, 1, 0, 0};
    vecs[4]  = '{4'h4, 16'hF0F0, 16'h0F0F, 1,  16'h0000, 16'h0000, 1, 1, 0};
    vecs[5]  = '{4'h5, 16'hF000, 16'h000F, 1,  16'hF00F, 16'h0000, 1, 0, 0};
    vecs[6]  = '{4'h6, 16'hA5A5, 16'hA5A5, 1,  16'h0000, 16'h0000, 1, 1, 0};
    vecs[7]  = '{4'h7, 16'h1234, 16'h0000, 1,  16'h1234, 16'h0000, 1, 0, 0};
    vecs[8]  = '{4'h8, 16'h0005, 16'h0000, 1,  16'h0005, 16'h0000, 1, 0, 1};
    vecs[9]  = '{4'h9, 16'h0005, 16'h0000, 1,  16'h0005, 16'h0000, 1, 0, 0};
    vecs[10] = '{4'h9, 16'h0000, 16'h0000, 1,  16'h0000, 16'h0000, 1, 0, 1};
    vecs[11] = '{4'hA, 16'd300,  16'd300,  17, 16'h5F90, 16'h0001, 1, 0, 0};
    vecs[12] = '{4'hB, 16'd100,  16'd7,    17, 16'd14,   16'd2,    0, 0, 0};
    vecs[13] = '{4'hB, 16'd9,    16'd0,    17, 16'hFFFF, 16'd9,    1, 0, 0};
    vecs[14] = '{4'hC, 16'h0001, 16'hABCD, 1,  16'hABCD, 16'h0000, 1, 0, 0};
    vecs[15] = '{4'hA, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 1, 0, 0};
    vecs[16] = '{4'hA, 16'h0100, 16'h0100, 17, 16'h0000, 16'h0001, 1, 1, 0};
    vecs[17] = '{4'hB, 16'd5,    16'd10,   17, 16'd0,    16'd5,    0, 1, 0};
    vecs[18] = '{4'h2, 16'h1234, 16'h1111, 1,  16'h2345, 16'h0000, 0, 0, 0};
    vecs[19] = '{4'h3, 16'h0007, 16'h0007, 1,  16'h0000, 16'h0000, 1, 1, 0};

    rst_n = 1'b0; start = 1'b0; alu_op = '0; mem = '0; wreg = '0;
    flag_load = 1'b0; flag_c_in = 1'b0; flag_z_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.outputs", {busy, done, result, result_hi, carry_out, zero_out, pc_skip}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // MUL with an ADD start at +3 cycles: ADD must be dropped
    @(negedge clk);
    alu_op = 4'hA; mem = 16'd300; wreg = 16'd300; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) begin alu_op = 4'h2; mem = 16'h0001; wreg = 16'h0001; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
        check("ovl.result", 32'(result), 32'h5F90);
        check("ovl.result_hi", 32'(result_hi), 32'h0001);
      end
    end
    check("ovl.done_count", 32'(done_cnt), 32'd1);
    check("ovl.done_at", 32'(done_at), 32'd17);
    check("ovl.idle_after", 32'(busy), 32'd0);

    // Reset asserted in the middle of a MUL aborts it
    @(negedge clk);
    alu_op = 4'hA; mem = 16'd300; wreg = 16'd300; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst.outputs", {busy, done, result, result_hi, carry_out, zero_out, pc_skip}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst.no_done", 32'(done_cnt), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);

    // flag_load while idle
    @(negedge clk);
    flag_load = 1'b1; flag_c_in = 1'b1; flag_z_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flag_load = 1'b0;
    check("fload.carry", 32'(carry_out), 32'd1);
    check("fload.zero", 32'(zero_out), 32'd0);

    // flag_load coinciding with done: op's flags win
    alu_op = 4'h2; mem = 16'h0001; wreg = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flag_load = 1'b1; flag_c_in = 1'b1; flag_z_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flag_load = 1'b0;
    check("fwin.done", 32'(done), 32'd1);
    check("fwin.result", 32'(result), 32'h0002);
    check("fwin.carry", 32'(carry_out), 32'd0);
    check("fwin.zero", 32'(zero_out), 32'd0);

    // Back-to-back: start held through the done cycle launches the next op
    @(negedge clk);
    alu_op = 4'h2; mem = 16'h0001; wreg = 16'h0002; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_op = 4'h6; mem = 16'h000F; wreg = 16'h000F;
    check("b2b.busy1", 32'(busy), 32'd1);
    check("b2b.done0", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b.done1", 32'(done), 32'd1);
    check("b2b.res1", 32'(result), 32'h0003);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b.gap_done", 32'(done), 32'd0);
    check("b2b.busy2", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b.done2", 32'(done), 32'd1);
    check("b2b.res2", 32'(result), 32'h0000);
    check("b2b.zero2", 32'(zero_out), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b.idle", 32'(busy), 32'd0);
    check("b2b.skip_low", 32'(pc_skip), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
